// File: rtl/ram_mc_pkg.sv
// Shared types and width helper for the multi-channel word RAM.
// Imported by the arbiter and by the ram_mc top.
package ram_mc_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int width_of(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// producing a one-hot-or-zero grant plus the granted index.
module rr_arbiter
    import ram_mc_pkg::*;
#(
    parameter int N  = 2,
    parameter int CW = width_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] gnt_idx,
    output logic          any
);

    int pick_s;

    function automatic int wrap(input int p, input int k);
        return (p + k) % N;
    endfunction

    // First requester at or after the pointer wins; nothing is granted when disabled.
    always_comb begin
        pick_s  = -1;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            pick_s = ((pick_s < 0) && req[wrap(int'(ptr), k)]) ? wrap(int'(ptr), k) : pick_s;
        end
        if (en && (pick_s >= 0)) begin
            gnt[pick_s] = 1'b1;
            gnt_idx     = CW'(pick_s);
            any         = 1'b1;
        end else begin
            gnt     = '0;
            gnt_idx = '0;
            any     = 1'b0;
        end
    end

endmodule

// File: rtl/ram_mc.sv
// Multi-channel word RAM: round-robin arbitrated req/gnt access to one array,
// registered read return, and a self-timed clearing sweep after reset.
module ram_mc
    import ram_mc_pkg::*;
#(
    parameter  int WORD_SIZE   = 27,
    parameter  int WORD_AMOUNT = 37,
    parameter  int CHANNELS    = 2,
    localparam int AW          = width_of(WORD_AMOUNT),
    localparam int CW          = width_of(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           req,
    input  logic [CHANNELS-1:0]           operation,
    input  logic [CHANNELS*AW-1:0]        address,
    input  logic [CHANNELS*WORD_SIZE-1:0] wdata,
    output logic [CHANNELS-1:0]           gnt,
    output logic [CHANNELS-1:0]           rvalid,
    output logic [CHANNELS*WORD_SIZE-1:0] rdata,
    output logic [CHANNELS-1:0]           oob,
    output logic                          ready
);

    state_e                          state_r;
    logic [AW-1:0]                   clr_cnt_r;
    logic [CW-1:0]                   ptr_r;
    logic                            ready_r;
    logic [CHANNELS-1:0]             rvalid_r;
    logic [CHANNELS-1:0]             oob_r;
    logic [CHANNELS*WORD_SIZE-1:0]   rdata_r;
    logic [WORD_SIZE-1:0]            mem_r [WORD_AMOUNT];

    logic [CHANNELS-1:0]             gnt_s;
    logic [CW-1:0]                   gnt_idx_s;
    logic                            any_s;
    logic [CW-1:0]                   ptr_next_s;
    op_e                             sel_op_s;
    logic [AW-1:0]                   sel_addr_s;
    logic [WORD_SIZE-1:0]            sel_wdata_s;
    logic                            in_range_s;
    logic [WORD_SIZE-1:0]            rd_word_s;
    logic                            mem_we_s;
    logic [AW-1:0]                   mem_waddr_s;
    logic [WORD_SIZE-1:0]            mem_wdata_s;

    rr_arbiter #(
        .N  (CHANNELS),
        .CW (CW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_r),
        .en      (state_r == ST_RUN),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign gnt    = gnt_s;
    assign rvalid = rvalid_r;
    assign oob    = oob_r;
    assign rdata  = rdata_r;
    assign ready  = ready_r;

    // Route the granted channel's request fields and look up its read word.
    always_comb begin
        sel_op_s    = op_e'(operation[gnt_idx_s]);
        sel_addr_s  = address[int'(gnt_idx_s)*AW +: AW];
        sel_wdata_s = wdata[int'(gnt_idx_s)*WORD_SIZE +: WORD_SIZE];
        // Widened compare so a WORD_AMOUNT equal to 2^AW still works.
        in_range_s  = ({1'b0, sel_addr_s} < (AW+1)'(WORD_AMOUNT));
        if (in_range_s) begin
            rd_word_s = mem_r[sel_addr_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Next round-robin pointer: one past the granted channel, wrapping.
    always_comb begin
        if (gnt_idx_s == CW'(CHANNELS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gnt_idx_s + CW'(1);
        end
    end

    // Single write port shared by the clear sweep and granted in-range writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_r;
            mem_wdata_s = '0;
        end else if (any_s && (sel_op_s == OP_WRITE) && in_range_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sel_addr_s;
            mem_wdata_s = sel_wdata_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; has no reset of its own, the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered read return, out-of-range flags and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ptr_r     <= '0;
            ready_r   <= 1'b0;
            rvalid_r  <= '0;
            oob_r     <= '0;
            rdata_r   <= '0;
        end else begin
            rvalid_r <= '0;
            oob_r    <= '0;
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + AW'(1);
                    if (clr_cnt_r == AW'(WORD_AMOUNT - 1)) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (any_s) begin
                        ptr_r <= ptr_next_s;
                        oob_r[gnt_idx_s] <= ~in_range_s;
                        if (sel_op_s == OP_READ) begin
                            rvalid_r[gnt_idx_s] <= 1'b1;
                            rdata_r[int'(gnt_idx_s)*WORD_SIZE +: WORD_SIZE] <= rd_word_s;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_mc.sv
// Self-checking bench for ram_mc: directed vector table, hand-written reset
// and clear sequences, and randomized traffic against a behavioural model.
module tb_ram_mc;

    localparam int WS = 27;
    localparam int WA = 37;
    localparam int CH = 2;
    localparam int AW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH-1:0]      req;
    logic [CH-1:0]      operation;
    logic [CH*AW-1:0]   address;
    logic [CH*WS-1:0]   wdata;
    logic [CH-1:0]      gnt;
    logic [CH-1:0]      rvalid;
    logic [CH*WS-1:0]   rdata;
    logic [CH-1:0]      oob;
    logic               ready;

    ram_mc #(.WORD_SIZE(WS), .WORD_AMOUNT(WA), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .req(req), .operation(operation), .address(address),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oob(oob), .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [WS-1:0] mem_m [WA];
    logic [WS-1:0] rdata_m [CH];
    logic [CH-1:0] rvalid_m, oob_m;
    logic          ready_m;
    int            ptr_m, clear_left;
    bit            known = 1'b0;
    logic [CH-1:0] obs_gnt, last_eg;
    logic          obs_ready;

    typedef struct {
        logic [1:0]    rq;
        logic [1:0]    op;
        int            a0, a1;
        logic [WS-1:0] d0, d1;
        logic [1:0]    g, rv, ob;
        logic [WS-1:0] r0, r1;
    } vec_t;
    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] model_gnt();
        logic [CH-1:0] g;
        g = '0;
        if (known && clear_left == 0) begin
            for (int k = 0; k < CH; k++) begin
                if (g == '0 && req[(ptr_m + k) % CH]) g[(ptr_m + k) % CH] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_edge(input logic [CH-1:0] eg);
        int a;
        if (rst) begin
            known = 1'b1; clear_left = WA; ptr_m = 0; ready_m = 1'b0;
            rvalid_m = '0; oob_m = '0;
            for (int i = 0; i < WA; i++) mem_m[i] = '0;
            for (int c = 0; c < CH; c++) rdata_m[c] = '0;
        end else if (known) begin
            rvalid_m = '0; oob_m = '0;
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) ready_m = 1'b1;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    if (eg[c]) begin
                        a = int'(address[c*AW +: AW]);
                        oob_m[c] = (a >= WA);
                        if (operation[c]) begin
                            if (a < WA) mem_m[a] = wdata[c*WS +: WS];
                        end else begin
                            rvalid_m[c] = 1'b1;
                            rdata_m[c]  = (a < WA) ? mem_m[a] : '0;
                        end
                        ptr_m = (c + 1) % CH;
                    end
                end
            end
        end
    endtask

    // One clock: gnt checked on the falling edge, registered outputs just after the rising edge.
    task automatic step();
        logic [CH-1:0] eg;
        @(negedge clk);
        eg = model_gnt();
        obs_gnt = gnt;
        obs_ready = ready;
        last_eg = eg;
        if (known) check("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        model_edge(eg);
        #1;
        if (known) begin
            check("rvalid", 32'(rvalid), 32'(rvalid_m));
            check("oob", 32'(oob), 32'(oob_m));
            check("ready", 32'(ready), 32'(ready_m));
            for (int c = 0; c < CH; c++) check("rdata", 32'(rdata[c*WS +: WS]), 32'(rdata_m[c]));
        end
    endtask

    task automatic set_ch(input int c, input logic r, input logic op, input int a, input logic [WS-1:0] d);
        req[c] = r;
        operation[c] = op;
        address[c*AW +: AW] = AW'(a);
        wdata[c*WS +: WS] = d;
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] op, input int a0, input int a1,
                                input logic [WS-1:0] d0, input logic [WS-1:0] d1, input logic [1:0] g,
                                input logic [1:0] rv, input logic [1:0] ob,
                                input logic [WS-1:0] r0, input logic [WS-1:0] r1);
        vec_t v;
        v.rq = rq; v.op = op; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g = g; v.rv = rv; v.ob = ob; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    initial begin
        int k, ngnt;
        logic [WS-1:0] A, B;
        A = 27'h5A5A5A5;
        B = 27'h1234567;
        // reads of 0/18/36, write-read pairs, round robin, out of range
        tbl[0]  = mk(2'b01, 2'b00,  0,  0, '0, '0, 2'b01, 2'b01, 2'b00, '0, '0);
        tbl[1]  = mk(2'b01, 2'b00, 18,  0, '0, '0, 2'b01, 2'b01, 2'b00, '0, '0);
        tbl[2]  = mk(2'b10, 2'b00,  0, 36, '0, '0, 2'b10, 2'b10, 2'b00, '0, '0);
        tbl[3]  = mk(2'b01, 2'b01,  5,  0,  A, '0, 2'b01, 2'b00, 2'b00, '0, '0);
        tbl[4]  = mk(2'b01, 2'b00,  5,  0, '0, '0, 2'b01, 2'b01, 2'b00,  A, '0);
        tbl[5]  = mk(2'b01, 2'b01,  7,  0,  B, '0, 2'b01, 2'b00, 2'b00,  A, '0);
        tbl[6]  = mk(2'b01, 2'b00,  7,  0, '0, '0, 2'b01, 2'b01, 2'b00,  B, '0);
        tbl[7]  = mk(2'b10, 2'b00,  7,  5, '0, '0, 2'b10, 2'b10, 2'b00,  B,  A);
        tbl[8]  = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b01, 2'b01, 2'b00,  B,  A);
        tbl[9]  = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b10, 2'b10, 2'b00,  B,  A);
        tbl[10] = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b01, 2'b01, 2'b00,  B,  A);
        tbl[11] = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b10, 2'b10, 2'b00,  B,  A);
        tbl[12] = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b01, 2'b01, 2'b00,  B,  A);
        tbl[13] = mk(2'b11, 2'b00,  7,  5, '0, '0, 2'b10, 2'b10, 2'b00,  B,  A);
        tbl[14] = mk(2'b10, 2'b10,  0, 37, '0, 27'h1, 2'b10, 2'b00, 2'b10, B,  A);
        tbl[15] = mk(2'b10, 2'b00,  0, 37, '0, '0, 2'b10, 2'b10, 2'b10,  B, '0);
        tbl[16] = mk(2'b10, 2'b00,  0,  0, '0, '0, 2'b10, 2'b10, 2'b00,  B, '0);
        tbl[17] = mk(2'b00, 2'b00,  0,  0, '0, '0, 2'b00, 2'b00, 2'b00,  B, '0);
        tbl[18] = mk(2'b01, 2'b00, 63,  0, '0, '0, 2'b01, 2'b01, 2'b01, '0, '0);
        tbl[19] = mk(2'b00, 2'b00,  0,  0, '0, '0, 2'b00, 2'b00, 2'b00, '0, '0);

        rst = 1'b1; req = '0; operation = '0; address = '0; wdata = '0;

        // clear sweep: ready must rise exactly WA cycles after reset release
        step();
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata[31:0]), 32'h0);
        rst = 1'b0;
        k = 0;
        while (ready !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        check("ready_latency", 32'(k), 32'(WA));

        // directed vector table
        for (int i = 0; i < 20; i++) begin
            req = tbl[i].rq; operation = tbl[i].op;
            address = {AW'(tbl[i].a1), AW'(tbl[i].a0)};
            wdata = {tbl[i].d1, tbl[i].d0};
            step();
            check("tbl_gnt", 32'(obs_gnt), 32'(tbl[i].g));
            check("tbl_rvalid", 32'(rvalid), 32'(tbl[i].rv));
            check("tbl_oob", 32'(oob), 32'(tbl[i].ob));
            check("tbl_rdata0", 32'(rdata[WS-1:0]), 32'(tbl[i].r0));
            check("tbl_rdata1", 32'(rdata[2*WS-1:WS]), 32'(tbl[i].r1));
        end

        // requests during clear are ignored; first grant lands when ready is high
        req = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        set_ch(0, 1'b1, 1'b0, 0, '0);
        ngnt = 0;
        for (int i = 0; i < WA; i++) begin
            step();
            if (obs_gnt != '0) ngnt++;
        end
        check("clear_gnt_count", 32'(ngnt), 32'h0);
        step();
        check("first_gnt", 32'(obs_gnt), 32'h1);
        check("first_gnt_ready", 32'(obs_ready), 32'h1);

        // reset in the rvalid cycle drops the read and restarts the sweep
        set_ch(0, 1'b1, 1'b1, 9, 27'h7654321);
        step();
        set_ch(0, 1'b1, 1'b0, 9, '0);
        step();
        check("mid_rvalid_pre", 32'(rvalid), 32'h1);
        check("mid_rdata_pre", 32'(rdata[WS-1:0]), 32'h7654321);
        req = '0; rst = 1'b1;
        step();
        check("mid_rvalid_rst", 32'(rvalid), 32'h0);
        check("mid_rdata_rst", 32'(rdata[WS-1:0]), 32'h0);
        check("mid_ready_rst", 32'(ready), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < WA; i++) step();
        check("mid_ready_after", 32'(ready), 32'h1);
        set_ch(0, 1'b1, 1'b0, 9, '0);
        step();
        check("mid_readback_valid", 32'(rvalid), 32'h1);
        check("mid_readback_data", 32'(rdata[WS-1:0]), 32'h0);

        // randomized traffic; an ungranted request is held unchanged
        req = '0;
        last_eg = '0;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (last_eg[c] || !req[c]) begin
                    set_ch(c, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                           ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63))
                                                       : int'($urandom_range(0, 36)),
                           WS'($urandom));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
